// File: rtl/tone_synth_mv.sv
// Multi-voice sine tone generator: per-voice phase accumulators time-multiplexed
// through one quarter-wave ROM, note changes deferred to the next phase wrap.
module tone_synth_mv #(
    parameter int BITS   = 6,
    parameter int VOICES = 2,
    parameter int MIX_W  = BITS + $clog2(VOICES) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_tick,
    input  logic [5*VOICES-1:0]     freq_id,
    input  logic                    rectify,
    output logic signed [MIX_W-1:0] mix_out,
    output logic                    mix_valid,
    output logic                    busy,
    output logic                    overrun
);
    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int SH = 11 - BITS;
    localparam logic [4:0] SILENT = 5'd31;
    localparam logic [4:0] FIRST_SILENT = 5'd25;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [15:0] inc_of(input logic [4:0] id);
        case (id)
            5'd0:  return 16'd1817;
            5'd1:  return 16'd1925;
            5'd2:  return 16'd2040;
            5'd3:  return 16'd2161;
            5'd4:  return 16'd2289;
            5'd5:  return 16'd2426;
            5'd6:  return 16'd2570;
            5'd7:  return 16'd2723;
            5'd8:  return 16'd2884;
            5'd9:  return 16'd3056;
            5'd10: return 16'd3238;
            5'd11: return 16'd3430;
            5'd12: return 16'd3634;
            5'd13: return 16'd3850;
            5'd14: return 16'd4079;
            5'd15: return 16'd4322;
            5'd16: return 16'd4579;
            5'd17: return 16'd4851;
            5'd18: return 16'd5140;
            5'd19: return 16'd5445;
            5'd20: return 16'd5769;
            5'd21: return 16'd6112;
            5'd22: return 16'd6475;
            5'd23: return 16'd6860;
            5'd24: return 16'd7268;
            default: return 16'd0;
        endcase
    endfunction

    // Elaboration-time round(1023*sin(pi*i/512)) via a Q30 Taylor series
    function automatic logic [9:0] sine_q(input int i);
        logic [63:0] x;
        logic [63:0] x2;
        logic [63:0] t;
        logic [63:0] s;
        x  = (64'd3373259426 * 64'(i)) >> 9;
        x2 = (x * x) >> 30;
        t  = x;
        s  = x;
        for (int n = 1; n <= 8; n++) begin
            t = ((t * x2) >> 30) / 64'((2 * n) * (2 * n + 1));
            if (n % 2 == 1) s = s - t;
            else            s = s + t;
        end
        return 10'((s * 64'd1023 + 64'd536870912) >> 30);
    endfunction

    logic [9:0] rom [257];
    for (genvar g = 0; g < 257; g++) begin : g_rom
        assign rom[g] = sine_q(g);
    end

    state_t                  state;
    logic [VW-1:0]           v;
    logic [15:0]             phase  [VOICES];
    logic [4:0]              active [VOICES];
    logic signed [MIX_W-1:0] acc;

    logic [15:0]             cur_ph;
    logic [15:0]             inc_a;
    logic [15:0]             inc_n;
    logic [16:0]             ph_sum;
    logic [4:0]              cur_act;
    logic [4:0]              cur_id;
    logic [8:0]              idx;
    logic [9:0]              q;
    logic [BITS-2:0]         mag;
    logic signed [MIX_W-1:0] smp;

    always_comb begin
        cur_ph  = phase[v];
        cur_act = active[v];
        cur_id  = freq_id[int'(v) * 5 +: 5];
        inc_a   = inc_of(cur_act);
        inc_n   = inc_of(cur_id);
        ph_sum  = {1'b0, cur_ph} + {1'b0, inc_a};
        idx     = cur_ph[14] ? 9'd256 - {1'b0, cur_ph[13:6]}
                             : {1'b0, cur_ph[13:6]};
        q       = rom[idx];
        mag     = (BITS - 1)'(q >> SH);
        smp     = (cur_ph[15] && !rectify) ? -$signed(MIX_W'(mag))
                                           : $signed(MIX_W'(mag));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            v         <= '0;
            acc       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                phase[i]  <= '0;
                active[i] <= SILENT;
            end
        end else begin
            mix_valid <= 1'b0;
            overrun   <= sample_tick && (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        v     <= '0;
                        acc   <= '0;
                    end
                end
                RUN: begin
                    acc <= acc + smp;
                    // A silent voice restarts from phase 0 with the new note at once
                    if (cur_act >= FIRST_SILENT) begin
                        active[v] <= cur_id;
                        phase[v]  <= (cur_id >= FIRST_SILENT) ? 16'd0 : inc_n;
                    end else if (ph_sum[16]) begin
                        active[v] <= cur_id;
                        phase[v]  <= (cur_id >= FIRST_SILENT) ? 16'd0
                                                              : ph_sum[15:0];
                    end else begin
                        phase[v] <= ph_sum[15:0];
                    end
                    if (v == VW'(VOICES - 1)) state <= DONE;
                    else                      v     <= v + 1'b1;
                end
                DONE: begin
                    mix_out   <= acc;
                    mix_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tone_synth_mv.sv
// Randomized bench for tone_synth_mv against a real-valued sine reference model.
module tb_tone_synth_mv;
    localparam int BITS   = 6;
    localparam int VOICES = 2;
    localparam int MIX_W  = BITS + $clog2(VOICES) + 1;
    localparam real PI    = 3.141592653589793;
    localparam int INC [32] = '{
        1817, 1925, 2040, 2161, 2289, 2426, 2570, 2723, 2884, 3056,
        3238, 3430, 3634, 3850, 4079, 4322, 4579, 4851, 5140, 5445,
        5769, 6112, 6475, 6860, 7268, 0, 0, 0, 0, 0, 0, 0};

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    sample_tick;
    logic [5*VOICES-1:0]     freq_id;
    logic                    rectify;
    logic signed [MIX_W-1:0] mix_out;
    logic                    mix_valid;
    logic                    busy;
    logic                    overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int m_ph  [VOICES];
    int m_act [VOICES];
    int fid   [VOICES];

    tone_synth_mv #(.BITS(BITS), .VOICES(VOICES)) dut (
        .clk(clk),
        .reset(reset),
        .sample_tick(sample_tick),
        .freq_id(freq_id),
        .rectify(rectify),
        .mix_out(mix_out),
        .mix_valid(mix_valid),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_sample(input int ph, input bit rect);
        int quad;
        int k;
        int idx;
        int q;
        int mag;
        quad = ph / 16384;
        k    = (ph / 64) % 256;
        idx  = (quad % 2 == 1) ? 256 - k : k;
        q    = int'($floor(1023.0 * $sin(PI * real'(idx) / 512.0) + 0.5));
        mag  = q / (2 ** (11 - BITS));
        return (quad >= 2 && !rect) ? -mag : mag;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < VOICES; v++) begin
            m_ph[v]  = 0;
            m_act[v] = 31;
        end
    endtask

    task automatic model_tick(output int mix);
        int n;
        mix = 0;
        for (int v = 0; v < VOICES; v++) begin
            mix += ref_sample(m_ph[v], rectify);
            if (m_act[v] >= 25) begin
                m_act[v] = fid[v];
                m_ph[v]  = INC[fid[v]];
            end else begin
                n = m_ph[v] + INC[m_act[v]];
                if (n >= 65536) begin
                    m_act[v] = fid[v];
                    m_ph[v]  = (fid[v] >= 25) ? 0 : n - 65536;
                end else begin
                    m_ph[v] = n;
                end
            end
        end
    endtask

    task automatic apply_ids();
        for (int v = 0; v < VOICES; v++) freq_id[5*v +: 5] = 5'(fid[v]);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_tick(input string tag, output int got);
        int exp;
        int lat;
        model_tick(exp);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (mix_valid) lat = i;
        end
        check({tag, "_lat"}, lat, VOICES + 1);
        check({tag, "_mix"}, int'(mix_out), exp);
        got = int'(mix_out);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int exp;
        int lo;
        int hi;
        int cnt;
        reset       = 1'b1;
        sample_tick = 1'b0;
        rectify     = 1'b0;
        for (int v = 0; v < VOICES; v++) fid[v] = 31;
        apply_ids();
        repeat (2) @(negedge clk);
        check("rst_mix", int'(mix_out), 0);
        check("rst_valid", int'(mix_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovr", int'(overrun), 0);
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < 5; i++) begin
            run_tick("silent", got);
            check("silent_ovr", int'(overrun), 0);
        end

        fid[0] = 24;
        apply_ids();
        for (int i = 0; i < 10; i++) begin
            run_tick("v24", got);
            if (i == 0) check("v24_first", got, 0);
        end

        lo = 1000;
        hi = -1000;
        for (int i = 0; i < 2000; i++) begin
            run_tick("signed", got);
            if (got < lo) lo = got;
            if (got > hi) hi = got;
        end
        check("signed_max", hi, 31);
        check("signed_min", lo, -31);
        rectify = 1'b1;
        lo = 1000;
        hi = -1000;
        for (int i = 0; i < 500; i++) begin
            run_tick("rect", got);
            if (got < lo) lo = got;
            if (got > hi) hi = got;
        end
        check("rect_max", hi, 31);
        check("rect_min", lo, 0);
        rectify = 1'b0;

        pulse_reset();
        fid[0] = 24;
        apply_ids();
        for (int i = 1; i <= 16; i++) begin
            if (i == 3) begin
                fid[0] = 0;
                apply_ids();
            end
            run_tick("notechg", got);
        end

        pulse_reset();
        fid[0] = 12;
        fid[1] = 12;
        apply_ids();
        for (int i = 0; i < 40; i++) begin
            run_tick("dual", got);
            check("dual_even", got & 1, 0);
            check("dual_2x", got, 2 * ref_sample((i * 3634) % 65536, 1'b0));
        end

        model_tick(exp);
        sample_tick = 1'b1;
        @(negedge clk);
        check("ovr_busy", int'(busy), 1);
        @(negedge clk);
        check("ovr_pulse", int'(overrun), 1);
        sample_tick = 1'b0;
        cnt = 0;
        @(negedge clk);
        check("ovr_clear", int'(overrun), 0);
        if (mix_valid) cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mix_valid) cnt++;
        end
        check("ovr_valids", cnt, 1);
        check("ovr_mix", int'(mix_out), exp);

        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("abort_mix", int'(mix_out), 0);
        check("abort_busy", int'(busy), 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (mix_valid) cnt++;
            @(negedge clk);
        end
        check("abort_valids", cnt, 0);

        for (int i = 0; i < 300; i++) begin
            for (int v = 0; v < VOICES; v++)
                if ($urandom_range(0, 3) == 0) fid[v] = $urandom_range(0, 31);
            apply_ids();
            if ($urandom_range(0, 7) == 0) rectify = ~rectify;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_tick("rand", got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
